// File: rtl/plot_framebuffer.sv
// rtl/plot_framebuffer.sv - 160x120x3-bit pixel-plot sink with clear engine, readback and plot counters
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   vga_x, vga_y, vga_colour        plot coordinate and colour
//   vga_plot                        plot strobe, one pixel per cycle while high
//   clear_start                     request a full-screen clear (accepted in IDLE only)
//   clear_done                      level, high once a clear has completed
//   busy                            high while the clear engine runs
//   rd_en, rd_x, rd_y               read request and coordinate
//   rd_valid, rd_colour             read result, one cycle after rd_en
//   plot_count                      accepted in-range plots, saturating
//   oob_count                       rejected out-of-range plots, saturating
module plot_framebuffer #(
    parameter int unsigned WIDTH        = 160,
    parameter int unsigned HEIGHT       = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_start,
    output logic        clear_done,
    output logic        busy,
    input  logic        rd_en,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    output logic [15:0] plot_count,
    output logic [7:0]  oob_count
);

    localparam int unsigned DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [14:0] clr_addr;

    logic [2:0]  mem [0:DEPTH-1];

    logic        plot_in_range;
    logic        rd_in_range;
    logic [14:0] plot_addr;
    logic [14:0] rd_addr;

    logic        start_clear;
    logic        plot_window;
    logic        mem_we;
    logic [14:0] mem_waddr;
    logic [2:0]  mem_wdata;

    assign plot_in_range = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    assign rd_in_range   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
    assign plot_addr     = 15'(32'(vga_y) * WIDTH + 32'(vga_x));
    assign rd_addr       = 15'(32'(rd_y) * WIDTH + 32'(rd_x));

    // plot_window marks the cycles in which a plot may be accepted; a
    // clear_start in IDLE takes priority and closes the window.
    always_comb begin
        state_nxt   = state;
        start_clear = 1'b0;
        plot_window = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    start_clear = 1'b1;
                    state_nxt   = CLEAR;
                end else begin
                    plot_window = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                plot_window = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single write port: the clear engine owns it in CLEAR, plots otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr;
        mem_wdata = CLEAR_COLOUR;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (plot_window && vga_plot && plot_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = plot_addr;
            mem_wdata = vga_colour;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_addr   <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            plot_count <= '0;
            oob_count  <= '0;
        end else begin
            state <= state_nxt;

            if (start_clear) begin
                clr_addr   <= '0;
                busy       <= 1'b1;
                clear_done <= 1'b0;
                plot_count <= '0;
                oob_count  <= '0;
            end else if (state == CLEAR) begin
                clr_addr <= clr_addr + 15'd1;
            end

            if (state == DONE) begin
                clear_done <= 1'b1;
                busy       <= 1'b0;
            end

            if (plot_window && vga_plot) begin
                if (plot_in_range) begin
                    if (plot_count != 16'hFFFF) begin
                        plot_count <= plot_count + 16'd1;
                    end
                end else if (oob_count != 8'hFF) begin
                    oob_count <= oob_count + 8'd1;
                end
            end
        end
    end

    // Pixel storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Nonblocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_colour <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_colour <= rd_in_range ? mem[rd_addr] : 3'b000;
            end
        end
    end

endmodule
